// File: rtl/rectangle128_keysched_ctrl_if.sv
// Host key-load / subkey-memory write bundle for the RECTANGLE-128 key schedule sequencer.
// The master side drives start and MasterKey. The slave side is the sequencer.
interface rectangle128_keysched_ctrl_if;
    logic         start;
    logic [127:0] MasterKey;
    logic         busy;
    logic         done;
    logic         mem_flush;
    logic         WE;
    logic [4:0]   WAddr;
    logic [63:0]  KeyIn;

    modport master (
        output start, MasterKey,
        input  busy, done, mem_flush, WE, WAddr, KeyIn
    );

    modport slave (
        input  start, MasterKey,
        output busy, done, mem_flush, WE, WAddr, KeyIn
    );
endinterface

// File: rtl/rectangle128_keysched_ctrl.sv
// RECTANGLE-128 key schedule sequencer.
// It clears the subkey memory, then writes K0..K25 to it, one subkey per cycle.
module rectangle128_keysched_ctrl #(
    parameter int unsigned NUM_SKEYS = 26,
    parameter logic [4:0]  RC_INIT   = 5'h01
) (
    input logic                         Clk,
    input logic                         flush,
    rectangle128_keysched_ctrl_if.slave ks
);
    typedef enum logic [1:0] {IDLE, CLR, GEN, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_SKEYS - 1);

    state_t       state, state_nxt;
    logic [127:0] rows, rows_nxt, rows_rnd;
    logic [4:0]   rc, rc_nxt;
    logic [4:0]   idx, idx_nxt;
    logic         busy_q, busy_nxt;
    logic         done_q, done_nxt;
    logic         mflush_q, mflush_nxt;
    logic         we_q, we_nxt;
    logic [4:0]   waddr_q, waddr_nxt;
    logic [63:0]  keyin_q, keyin_nxt;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h6;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'hC;  4'h3: sbox = 4'hA;
            4'h4: sbox = 4'h1;  4'h5: sbox = 4'hE;  4'h6: sbox = 4'h7;  4'h7: sbox = 4'h9;
            4'h8: sbox = 4'hB;  4'h9: sbox = 4'h0;  4'hA: sbox = 4'h3;  4'hB: sbox = 4'hD;
            4'hC: sbox = 4'h8;  4'hD: sbox = 4'hF;  4'hE: sbox = 4'h4;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] subkey(input logic [127:0] k);
        return {k[111:96], k[79:64], k[47:32], k[15:0]};
    endfunction

    // S-box on the low 8 columns, then one Feistel step with the round constant in row0.
    function automatic logic [127:0] key_round(input logic [127:0] k, input logic [4:0] c);
        logic [31:0] r0, r1, r2, r3, n0;
        logic [3:0]  s;
        r0 = k[31:0];
        r1 = k[63:32];
        r2 = k[95:64];
        r3 = k[127:96];
        for (int j = 0; j < 8; j++) begin
            s     = sbox({r3[j], r2[j], r1[j], r0[j]});
            r0[j] = s[0];
            r1[j] = s[1];
            r2[j] = s[2];
            r3[j] = s[3];
        end
        n0      = {r0[23:0], r0[31:24]} ^ r1;
        n0[4:0] = n0[4:0] ^ c;
        return {{r3[15:0], r3[31:16]} ^ r0, r3, r2, n0};
    endfunction

    assign rows_rnd = key_round(rows, rc);

    always_comb begin
        state_nxt  = state;
        rows_nxt   = rows;
        rc_nxt     = rc;
        idx_nxt    = idx;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        mflush_nxt = 1'b1;
        we_nxt     = 1'b0;
        waddr_nxt  = waddr_q;
        keyin_nxt  = keyin_q;
        case (state)
            IDLE: begin
                if (ks.start) begin
                    state_nxt  = CLR;
                    rows_nxt   = ks.MasterKey;
                    rc_nxt     = RC_INIT;
                    idx_nxt    = 5'd0;
                    busy_nxt   = 1'b1;
                    mflush_nxt = 1'b0;
                end
            end
            CLR: begin
                state_nxt = GEN;
                busy_nxt  = 1'b1;
                we_nxt    = 1'b1;
                waddr_nxt = idx;
                keyin_nxt = subkey(rows);
            end
            GEN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    rows_nxt  = rows_rnd;
                    rc_nxt    = {rc[3:0], rc[4] ^ rc[2]};
                    idx_nxt   = idx + 5'd1;
                    busy_nxt  = 1'b1;
                    we_nxt    = 1'b1;
                    waddr_nxt = idx + 5'd1;
                    keyin_nxt = subkey(rows_rnd);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode, so they line up with the state.
    always_ff @(posedge Clk or negedge flush) begin
        if (!flush) begin
            state    <= IDLE;
            rows     <= '0;
            rc       <= RC_INIT;
            idx      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mflush_q <= 1'b1;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            keyin_q  <= '0;
        end else begin
            state    <= state_nxt;
            rows     <= rows_nxt;
            rc       <= rc_nxt;
            idx      <= idx_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            mflush_q <= mflush_nxt;
            we_q     <= we_nxt;
            waddr_q  <= waddr_nxt;
            keyin_q  <= keyin_nxt;
        end
    end

    assign ks.busy      = busy_q;
    assign ks.done      = done_q;
    assign ks.mem_flush = mflush_q;
    assign ks.WE        = we_q;
    assign ks.WAddr     = waddr_q;
    assign ks.KeyIn     = keyin_q;
endmodule
